// File: rtl/mult_ctrl_pkg.sv
// Shared constants and state encoding for the sequential 8x8 shift-and-add multiplier.
package mult_ctrl_pkg;

    localparam int unsigned W     = 8;
    localparam int unsigned CNT_W = 3;

    localparam logic [CNT_W-1:0] CNT_LAST = 3'd7;
    localparam logic [1:0]       OP_ADD   = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mult_norm_shr.sv
// Right shifter (0..7) that realigns an early-terminated product; used only with MULT_EARLY_TERM_EN.
module mult_norm_shr
    import mult_ctrl_pkg::*;
(
    input  logic [2*W-1:0]   din,
    input  logic [CNT_W-1:0] sh,
    output logic [2*W-1:0]   dout_c
);

    assign dout_c = din >> sh;

endmodule

// File: rtl/mult_seq_ctrl_8b.sv
// Sequential 8x8 unsigned shift-and-add multiplier controller driving an external ula_8b as its adder.
// Optional macro MULT_EARLY_TERM_EN: stop iterating once no multiplier ones remain.
module mult_seq_ctrl_8b
    import mult_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic           alu_x,
    output logic           alu_y,
    input  logic [W-1:0]   alu_s,
    input  logic           alu_c
);

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     acc_hi;
    logic [W-1:0]     q;
    logic [W-1:0]     mcand;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             step;
    logic             finish;
    logic             last_iter;
    logic [2*W-1:0]   sum_c;
    logic [2*W-1:0]   prod_c;

    assign alu_a = acc_hi;
    assign alu_b = q[0] ? mcand : '0;
    assign alu_x = OP_ADD[1];
    assign alu_y = OP_ADD[0];

    // Value {acc_hi,q} takes after this iteration's add-and-shift.
    assign sum_c = {alu_c, alu_s, q[W-1:1]};

`ifdef MULT_EARLY_TERM_EN
    logic [W-1:0] mrem;

    assign last_iter = (cnt == CNT_LAST) || (mrem[W-1:1] == '0);

    // An early exit leaves the product (7-k) places too far left.
    mult_norm_shr u_norm_shr (
        .din    (sum_c),
        .sh     (CNT_LAST - cnt),
        .dout_c (prod_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mrem <= '0;
        end else if (load) begin
            mrem <= b;
        end else if (step) begin
            mrem <= mrem >> 1;
        end
    end
`else
    assign last_iter = (cnt == CNT_LAST);
    assign prod_c    = sum_c;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (last_iter) begin
                    finish    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hi <= '0;
            q      <= '0;
            mcand  <= '0;
            cnt    <= '0;
            p      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (load) begin
                mcand  <= a;
                q      <= b;
                acc_hi <= '0;
                cnt    <= '0;
            end else if (step) begin
                acc_hi <= {alu_c, alu_s[W-1:1]};
                q      <= {alu_s[0], q[W-1:1]};
                cnt    <= cnt + CNT_W'(1);
            end
            if (finish) begin
                p <= prod_c;
            end
            busy <= (state_nxt == ST_RUN);
            done <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl_8b.sv
// Self-checking bench for mult_seq_ctrl_8b with a behavioural ula_8b add path and an arithmetic reference.
module tb_mult_seq_ctrl_8b;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] p;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_x;
    logic        alu_y;
    logic [7:0]  alu_s;
    logic        alu_c;

    int n_asrt;
    int n_fail;
    logic [15:0] prev_p;

    mult_seq_ctrl_8b dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p),
        .alu_a (alu_a),
        .alu_b (alu_b),
        .alu_x (alu_x),
        .alu_y (alu_y),
        .alu_s (alu_s),
        .alu_c (alu_c)
    );

    // ula_8b add operation: {c,s} = a + b
    assign {alu_c, alu_s} = 9'(alu_a) + 9'(alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RUN cycles expected for a given multiplier
    function automatic int ref_cycles(input logic [7:0] bv);
        int hi;
        hi = 0;
        for (int i = 0; i < 8; i++) if (bv[i]) hi = i;
`ifdef MULT_EARLY_TERM_EN
        return hi + 1;
`else
        return (hi >= 0) ? 8 : 0;
`endif
    endfunction

    function automatic logic [15:0] ref_prod(input logic [7:0] av, input logic [7:0] bv);
        return 16'(av) * 16'(bv);
    endfunction

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input string tag);
        logic [15:0] exp_p;
        int          n;
        exp_p = ref_prod(av, bv);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_p_held"}, 32'(p), 32'(prev_p));
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_cycles"}, 32'(n), 32'(ref_cycles(bv)));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_p"}, 32'(p), 32'(exp_p));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_p_stable"}, 32'(p), 32'(exp_p));
        prev_p = exp_p;
    endtask

    initial begin
        int n;
        n_asrt = 0;
        n_fail = 0;
        prev_p = 16'h0000;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = 8'h00;
        b      = 8'h00;

        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_p", 32'(p), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("alu_xy_add", 32'({alu_x, alu_y}), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        run_op(8'd10, 8'd20, "a10_b20");
        run_op(8'd255, 8'd255, "a255_b255");
        run_op(8'd200, 8'd1, "a200_b1");
        run_op(8'd77, 8'd0, "b0");
        run_op(8'd0, 8'd183, "a0");
        run_op(8'd1, 8'd128, "b128");

        // start re-pulsed with new operands 3 cycles into RUN must be ignored
        @(negedge clk);
        a = 8'd10; b = 8'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            if (n == 3) begin
                a = 8'd99; b = 8'd77; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("ign_cycles", 32'(n), 32'(ref_cycles(8'd20)));
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_p", 32'(p), 32'(ref_prod(8'd10, 8'd20)));
        @(negedge clk);
        chk("ign_no_restart", 32'(busy), 32'd0);
        prev_p = ref_prod(8'd10, 8'd20);

        // start held through DONE: back-to-back operations
        @(negedge clk);
        a = 8'd37; b = 8'd211; start = 1'b1;
        @(negedge clk);
        a = 8'd143; b = 8'd9;
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_first_done", 32'(done), 32'd1);
        chk("b2b_first_p", 32'(p), 32'(ref_prod(8'd37, 8'd211)));
        @(negedge clk);
        start = 1'b0;
        chk("b2b_rerun_busy", 32'(busy), 32'd1);
        chk("b2b_rerun_done", 32'(done), 32'd0);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_second_cycles", 32'(n), 32'(ref_cycles(8'd9)));
        chk("b2b_second_done", 32'(done), 32'd1);
        chk("b2b_second_p", 32'(p), 32'(ref_prod(8'd143, 8'd9)));
        @(negedge clk);
        chk("b2b_second_pulse", 32'(done), 32'd0);
        prev_p = ref_prod(8'd143, 8'd9);

        // reset in the middle of a run (iteration counter at 4)
        @(negedge clk);
        a = 8'd123; b = 8'd231; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_p", 32'(p), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        prev_p = 16'h0000;
        run_op(8'd123, 8'd231, "post_rst");

        // randomized operands
        for (int i = 0; i < 16; i++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
